// File: rtl/sdio_xfer_seq_if.sv
`default_nettype none
// ============================================================================
// sdio_xfer_seq_if : register-file, engine and uDMA signals of the sequencer
// Revision: 1.0
// ============================================================================
interface sdio_xfer_seq_if #(
  parameter int BLKNUM_W  = 16,
  parameter int TIMEOUT_W = 24
);
  logic                 clr_stat;
  logic                 cmd_start;
  logic [5:0]           cmd_op;
  logic [31:0]          cmd_arg;
  logic [2:0]           cmd_rsp_type;
  logic [5:0]           stopcmd_op;
  logic [31:0]          stopcmd_arg;
  logic [2:0]           stopcmd_rsp_type;
  logic                 data_en;
  logic                 data_rwn;
  logic [BLKNUM_W-1:0]  data_block_num;
  logic [1:0]           auto_mode;
  logic [TIMEOUT_W-1:0] timeout;

  logic                 eng_cmd_start;
  logic [5:0]           eng_cmd_op;
  logic [31:0]          eng_cmd_arg;
  logic [2:0]           eng_cmd_rsp_type;
  logic                 eng_cmd_eot;
  logic                 eng_cmd_err;
  logic                 eng_start_read;
  logic                 eng_start_write;
  logic                 eng_data_start;
  logic                 eng_data_last;
  logic                 eng_data_eot;
  logic                 eng_data_err;

  logic                 busy;
  logic                 eot;
  logic                 err;
  logic [7:0]           status;

  modport master (
    output clr_stat, cmd_start, cmd_op, cmd_arg, cmd_rsp_type,
           stopcmd_op, stopcmd_arg, stopcmd_rsp_type,
           data_en, data_rwn, data_block_num, auto_mode, timeout,
           eng_cmd_eot, eng_cmd_err, eng_start_read, eng_start_write,
           eng_data_last, eng_data_eot, eng_data_err,
    input  eng_cmd_start, eng_cmd_op, eng_cmd_arg, eng_cmd_rsp_type,
           eng_data_start, busy, eot, err, status
  );

  modport slave (
    input  clr_stat, cmd_start, cmd_op, cmd_arg, cmd_rsp_type,
           stopcmd_op, stopcmd_arg, stopcmd_rsp_type,
           data_en, data_rwn, data_block_num, auto_mode, timeout,
           eng_cmd_eot, eng_cmd_err, eng_start_read, eng_start_write,
           eng_data_last, eng_data_eot, eng_data_err,
    output eng_cmd_start, eng_cmd_op, eng_cmd_arg, eng_cmd_rsp_type,
           eng_data_start, busy, eot, err, status
  );
endinterface
`default_nettype wire

// File: rtl/sdio_xfer_seq.sv
`default_nettype none
// ============================================================================
// sdio_xfer_seq : uDMA SDIO transfer sequencer (auto-CMD12/CMD23, timeout)
// Revision: 1.0
// ============================================================================
module sdio_xfer_seq #(
  parameter int BLKNUM_W      = 16,
  parameter int TIMEOUT_W     = 24,
  parameter bit AUTO_CMD23_EN = 1'b1
) (
  input  wire logic      clk_i,
  input  wire logic      rst_i,
  sdio_xfer_seq_if.slave bus
);
  localparam logic [5:0] c_OP_CMD23   = 6'd23;
  localparam logic [1:0] c_MODE_NONE  = 2'b00;
  localparam logic [1:0] c_MODE_CMD12 = 2'b01;
  localparam logic [1:0] c_MODE_CMD23 = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PRE_CMD   = 4'd1,
    ST_PRE_WAIT  = 4'd2,
    ST_MAIN_CMD  = 4'd3,
    ST_MAIN_WAIT = 4'd4,
    ST_DATA_WAIT = 4'd5,
    ST_STOP_CMD  = 4'd6,
    ST_STOP_WAIT = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  state_t               r_state;
  logic [5:0]           r_op;
  logic [31:0]          r_arg;
  logic [2:0]           r_rsp;
  logic [5:0]           r_stop_op;
  logic [31:0]          r_stop_arg;
  logic [2:0]           r_stop_rsp;
  logic                 r_data_en;
  logic                 r_rwn;
  logic [BLKNUM_W-1:0]  r_blk;
  logic [1:0]           r_mode;
  logic [TIMEOUT_W-1:0] r_timeout;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_cmd_seen;
  logic                 r_data_started;
  logic                 r_data_eot_seen;
  logic                 r_err_acc;
  logic                 r_eng_start;
  logic [5:0]           r_eng_op;
  logic [31:0]          r_eng_arg;
  logic [2:0]           r_eng_rsp;
  logic                 r_busy;
  logic                 r_eot;
  logic                 r_err;
  logic [5:0]           r_status;

  logic [1:0] w_mode_in;
  logic       w_active;
  logic       w_wait;
  logic       w_err;
  logic       w_to_hit;
  logic       w_fail;
  logic       w_data_start;
  logic [5:0] w_stat_set;

  // Unsupported or reserved modes collapse to "no auto command" at accept time.
  if (AUTO_CMD23_EN) begin : g_cmd23_on
    assign w_mode_in = (bus.auto_mode == 2'b11) ? c_MODE_NONE : bus.auto_mode;
  end else begin : g_cmd23_off
    assign w_mode_in = (bus.auto_mode == c_MODE_CMD12) ? c_MODE_CMD12 : c_MODE_NONE;
  end

  always_comb begin
    w_active     = (r_state != ST_IDLE);
    w_wait       = (r_state inside {ST_PRE_WAIT, ST_MAIN_WAIT, ST_DATA_WAIT, ST_STOP_WAIT});
    w_err        = w_active && (bus.eng_cmd_err || bus.eng_data_err);
    w_to_hit     = w_wait && (r_timeout != '0) && (r_cnt == r_timeout);
    w_fail       = w_err || w_to_hit;
    w_data_start = (r_state == ST_MAIN_WAIT) && r_data_en && !r_data_started &&
                   (r_rwn ? bus.eng_start_read : bus.eng_start_write);
    w_stat_set   = {(r_state == ST_STOP_CMD),
                    (r_state == ST_PRE_WAIT) && bus.eng_cmd_eot && !w_fail,
                    bus.cmd_start && r_busy,
                    w_to_hit,
                    w_active && bus.eng_data_err,
                    w_active && bus.eng_cmd_err};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_op            <= '0;
      r_arg           <= '0;
      r_rsp           <= '0;
      r_stop_op       <= '0;
      r_stop_arg      <= '0;
      r_stop_rsp      <= '0;
      r_data_en       <= 1'b0;
      r_rwn           <= 1'b0;
      r_blk           <= '0;
      r_mode          <= '0;
      r_timeout       <= '0;
      r_cnt           <= '0;
      r_cmd_seen      <= 1'b0;
      r_data_started  <= 1'b0;
      r_data_eot_seen <= 1'b0;
      r_err_acc       <= 1'b0;
      r_eng_start     <= 1'b0;
      r_eng_op        <= '0;
      r_eng_arg       <= '0;
      r_eng_rsp       <= '0;
      r_busy          <= 1'b0;
      r_eot           <= 1'b0;
      r_err           <= 1'b0;
      r_status        <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_eot       <= 1'b0;
      r_err       <= 1'b0;
      r_status    <= (bus.clr_stat ? 6'd0 : r_status) | w_stat_set;
      r_cnt       <= w_wait ? (r_cnt + TIMEOUT_W'(1)) : '0;

      if (w_fail && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
        r_state   <= ST_DONE;
        r_err_acc <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // The eot cycle is spent here with busy still high.
            r_busy <= 1'b0;
            if (bus.cmd_start && !r_busy) begin
              r_busy          <= 1'b1;
              r_op            <= bus.cmd_op;
              r_arg           <= bus.cmd_arg;
              r_rsp           <= bus.cmd_rsp_type;
              r_stop_op       <= bus.stopcmd_op;
              r_stop_arg      <= bus.stopcmd_arg;
              r_stop_rsp      <= bus.stopcmd_rsp_type;
              r_data_en       <= bus.data_en;
              r_rwn           <= bus.data_rwn;
              r_blk           <= bus.data_block_num;
              r_mode          <= w_mode_in;
              r_timeout       <= bus.timeout;
              r_cmd_seen      <= 1'b0;
              r_data_started  <= 1'b0;
              r_data_eot_seen <= 1'b0;
              r_err_acc       <= 1'b0;
              r_eng_start     <= 1'b1;
              if ((w_mode_in == c_MODE_CMD23) && bus.data_en) begin
                r_state   <= ST_PRE_CMD;
                r_eng_op  <= c_OP_CMD23;
                r_eng_arg <= 32'(bus.data_block_num) + 32'd1;
                r_eng_rsp <= bus.stopcmd_rsp_type;
              end else begin
                r_state   <= ST_MAIN_CMD;
                r_eng_op  <= bus.cmd_op;
                r_eng_arg <= bus.cmd_arg;
                r_eng_rsp <= bus.cmd_rsp_type;
              end
            end
          end
          ST_PRE_CMD: r_state <= ST_PRE_WAIT;
          ST_PRE_WAIT: begin
            if (bus.eng_cmd_eot) begin
              r_state     <= ST_MAIN_CMD;
              r_eng_start <= 1'b1;
              r_eng_op    <= r_op;
              r_eng_arg   <= r_arg;
              r_eng_rsp   <= r_rsp;
            end
          end
          ST_MAIN_CMD: begin
            r_state    <= ST_MAIN_WAIT;
            r_cmd_seen <= 1'b0;
          end
          ST_MAIN_WAIT: begin
            if (bus.eng_cmd_eot) r_cmd_seen <= 1'b1;
            if (w_data_start) r_data_started <= 1'b1;
            if (!r_data_en) begin
              if (bus.eng_cmd_eot) r_state <= ST_DONE;
            end else if ((r_cmd_seen || bus.eng_cmd_eot) && (r_data_started || w_data_start)) begin
              r_state <= ST_DATA_WAIT;
              r_cnt   <= '0;
            end
          end
          ST_DATA_WAIT: begin
            if (bus.eng_data_eot) r_data_eot_seen <= 1'b1;
            if ((r_mode == c_MODE_CMD12) && (r_blk != '0)) begin
              if (bus.eng_data_last) begin
                r_state     <= ST_STOP_CMD;
                r_cmd_seen  <= 1'b0;
                r_eng_start <= 1'b1;
                r_eng_op    <= r_stop_op;
                r_eng_arg   <= r_stop_arg;
                r_eng_rsp   <= r_stop_rsp;
              end
            end else if (bus.eng_data_eot) begin
              r_state <= ST_DONE;
            end
          end
          ST_STOP_CMD: begin
            // Data eot may trail the last-block pulse by a cycle or two.
            if (bus.eng_data_eot) r_data_eot_seen <= 1'b1;
            r_state <= ST_STOP_WAIT;
          end
          ST_STOP_WAIT: begin
            if (bus.eng_cmd_eot) r_cmd_seen <= 1'b1;
            if (bus.eng_data_eot) r_data_eot_seen <= 1'b1;
            if ((r_cmd_seen || bus.eng_cmd_eot) && (r_data_eot_seen || bus.eng_data_eot))
              r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_eot   <= 1'b1;
            r_err   <= r_err_acc || w_err;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.eng_cmd_start    = r_eng_start;
  assign bus.eng_cmd_op       = r_eng_op;
  assign bus.eng_cmd_arg      = r_eng_arg;
  assign bus.eng_cmd_rsp_type = r_eng_rsp;
  assign bus.eng_data_start   = w_data_start;
  assign bus.busy             = r_busy;
  assign bus.eot              = r_eot;
  assign bus.err              = r_err;
  assign bus.status           = {2'b00, r_status};
endmodule
`default_nettype wire
